// File: rtl/laa_mult_regfile.sv
// LAA execution stage: 32-entry register file plus a sequential radix-2 shift-add
// multiplier whose result lands in r3/r4 and whose completion sets status register r31.
module laa_mult_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_MULT  = 2'd3;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                           state_reg, state_next;
    logic [NREGS-1:0][DATA_W-1:0]     regs_reg, regs_next;
    logic [1:0]                       prev_op_reg;
    logic [2*DATA_W-1:0]              a_reg, a_next;
    logic [2*DATA_W-1:0]              b_reg, b_next;
    logic [2*DATA_W-1:0]              acc_reg, acc_next;
    logic [CNT_W-1:0]                 count_reg, count_next;
    logic                             start;
    logic                             result_wr;
    logic                             addr_valid;

    // Edge-detect on MULTIPLY so a decoder stalled on the opcode starts only one run.
    assign start      = (opcode == OP_MULT) && (prev_op_reg != OP_MULT) && (state_reg == ST_IDLE);
    assign result_wr  = (state_reg == ST_DONE);
    assign addr_valid = (32'(addr) < NREGS);
    assign busy       = (state_reg != ST_IDLE);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic wr_hit;
            assign wr_hit = (opcode == OP_WRITE) && (addr == ADDR_W'(gi));

            // Engine result has priority over a bus write in the DONE cycle.
            if (gi == 3) begin : g_lo
                assign regs_next[gi] = result_wr ? acc_reg[DATA_W-1:0]
                                     : (wr_hit ? data_in : regs_reg[gi]);
            end else if (gi == 4) begin : g_hi
                assign regs_next[gi] = result_wr ? acc_reg[2*DATA_W-1:DATA_W]
                                     : (wr_hit ? data_in : regs_reg[gi]);
            end else if (gi == NREGS - 1) begin : g_status
                assign regs_next[gi] = result_wr ? DATA_W'(1)
                                     : ((start || wr_hit) ? '0 : regs_reg[gi]);
            end else begin : g_plain
                assign regs_next[gi] = wr_hit ? data_in : regs_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_BUSY;
                    a_next     = {{DATA_W{1'b0}}, regs_reg[1]};
                    b_next     = {{DATA_W{1'b0}}, regs_reg[2]};
                    acc_next   = '0;
                    count_next = '0;
                end
            end
            ST_BUSY: begin
                if (b_reg[0]) begin
                    acc_next = acc_reg + a_reg;
                end
                a_next     = a_reg << 1;
                b_next     = b_reg >> 1;
                count_next = count_reg + CNT_W'(1);
                if (count_reg == CNT_W'(DATA_W - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_reg   <= ST_IDLE;
            regs_reg    <= '0;
            prev_op_reg <= OP_NONE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            data_out    <= '0;
        end else begin
            state_reg   <= state_next;
            regs_reg    <= regs_next;
            prev_op_reg <= opcode;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            if (opcode == OP_READ) begin
                data_out <= addr_valid ? regs_reg[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_laa_mult_regfile.sv
// Directed self-checking bench for laa_mult_regfile: register file access,
// multiply results, MULTIPLY edge detection, writes while busy and mid-run reset.
module tb_laa_mult_regfile;

    logic        clk = 1'b0;
    logic        Rst;
    logic [1:0]  opcode;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    laa_mult_regfile #(.DATA_W(32), .NREGS(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .Rst      (Rst),
        .opcode   (opcode),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        opcode = 2'd2; addr = a; data_in = d;
        step();
        opcode = 2'd0;
        $display("WRITE r%0d = 0x%08h", a, d);
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        opcode = 2'd1; addr = a;
        step();
        d = data_out;
        opcode = 2'd0;
        $display("READ  r%0d -> 0x%08h", a, d);
    endtask

    task automatic start_mult();
        opcode = 2'd3;
        step();
        opcode = 2'd0;
        $display("MULTIPLY issued for one cycle");
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            step();
        end
        if (cycles >= 100) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        Rst = 1'b1; opcode = 2'd0; addr = '0; data_in = '0;
        repeat (3) step();
        Rst = 1'b0;
        checks++;
        if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out: got 0x%08h required 0", data_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), d);
            checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL reset_r%0d: got 0x%08h required 0", i, d); end
        end
    endtask

    task automatic test_basic_mult();
        logic [31:0] d;
        int cyc;
        do_write(5'd1, 32'd6);
        do_write(5'd2, 32'd7);
        start_mult();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start: got %b required 1", busy); end
        wait_idle(cyc);
        checks++;
        if (cyc != 33) begin failures++; $display("FAIL basic_busy_len: got %0d required 33", cyc); end
        do_read(5'd31, d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL basic_r31: got 0x%08h required 1", d); end
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd42) begin failures++; $display("FAIL basic_r3: got 0x%08h required 42", d); end
        do_read(5'd4, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL basic_r4: got 0x%08h required 0", d); end
    endtask

    task automatic test_max_mult();
        logic [31:0] d;
        int cyc;
        do_write(5'd1, 32'hFFFF_FFFF);
        do_write(5'd2, 32'hFFFF_FFFF);
        start_mult();
        wait_idle(cyc);
        do_read(5'd3, d);
        checks++;
        if (d !== 32'h0000_0001) begin failures++; $display("FAIL max_r3: got 0x%08h required 0x00000001", d); end
        do_read(5'd4, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL max_r4: got 0x%08h required 0xfffffffe", d); end
    endtask

    task automatic test_held_multiply();
        logic [31:0] d;
        int busy_cnt;
        do_write(5'd1, 32'd10);
        do_write(5'd2, 32'd20);
        busy_cnt = 0;
        opcode = 2'd3;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        opcode = 2'd0;
        $display("MULTIPLY held 40 cycles, busy for %0d", busy_cnt);
        checks++;
        if (busy_cnt != 33) begin failures++; $display("FAIL held_busy_len: got %0d required 33", busy_cnt); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL held_no_restart: busy=%b required 0", busy); end
        do_read(5'd31, d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL held_r31: got 0x%08h required 1", d); end
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd200) begin failures++; $display("FAIL held_r3: got 0x%08h required 200", d); end
    endtask

    task automatic test_write_while_busy();
        logic [31:0] d;
        int cyc;
        do_write(5'd1, 32'd3);
        do_write(5'd2, 32'd5);
        start_mult();
        repeat (3) step();
        do_write(5'd1, 32'd100);
        do_read(5'd31, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL busy_r31: got 0x%08h required 0", d); end
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd200) begin failures++; $display("FAIL busy_r3_old: got 0x%08h required 200", d); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b required 1", busy); end
        wait_idle(cyc);
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd15) begin failures++; $display("FAIL latched_r3: got 0x%08h required 15", d); end
        do_read(5'd4, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL latched_r4: got 0x%08h required 0", d); end
        do_read(5'd1, d);
        checks++;
        if (d !== 32'd100) begin failures++; $display("FAIL latched_r1: got 0x%08h required 100", d); end
    endtask

    task automatic test_status_clear();
        logic [31:0] d;
        do_write(5'd31, 32'hDEAD_BEEF);
        do_read(5'd31, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL r31_clear: got 0x%08h required 0", d); end
        do_write(5'd10, 32'hA5A5_0F0F);
        do_read(5'd10, d);
        checks++;
        if (d !== 32'hA5A5_0F0F) begin failures++; $display("FAIL r10_rw: got 0x%08h required 0xa5a50f0f", d); end
    endtask

    task automatic test_done_collision();
        logic [31:0] d;
        do_write(5'd1, 32'd9);
        do_write(5'd2, 32'd9);
        start_mult();
        repeat (32) step();
        opcode = 2'd2; addr = 5'd3; data_in = 32'h0000_0BAD;
        step();
        opcode = 2'd0;
        $display("WRITE r3 = 0x00000bad in DONE cycle");
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL done_busy: got %b required 0", busy); end
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd81) begin failures++; $display("FAIL done_r3_wins: got 0x%08h required 81", d); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        int cyc;
        do_write(5'd1, 32'd7);
        do_write(5'd2, 32'd7);
        start_mult();
        repeat (9) step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy: got %b required 1", busy); end
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        $display("Rst pulsed mid-multiply");
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++;
        if (data_out !== 32'd0) begin failures++; $display("FAIL rst_data_out: got 0x%08h required 0", data_out); end
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), d);
            checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL rst_r%0d: got 0x%08h required 0", i, d); end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_stays_idle: got %b required 0", busy); end
        do_write(5'd1, 32'd2);
        do_write(5'd2, 32'd2);
        start_mult();
        wait_idle(cyc);
        do_read(5'd3, d);
        checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL post_rst_r3: got 0x%08h required 4", d); end
    endtask

    initial begin
        test_reset();
        test_basic_mult();
        test_max_mult();
        test_held_multiply();
        test_write_while_busy();
        test_status_clear();
        test_done_collision();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
